pipe_stage_latch: RTL and testbench

Parametrised pipeline-stage register with a valid/ready handshake, synchronous flush and bubble insertion, used between any two stages of the pipelined CPU (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a control field, which is forced to zero whenever the stage holds a bubble, and a payload field (PC, operands, ALU result, immediates). Stalls propagate backwards without combinational ready paths when the optional skid buffer is compiled in.

---
 rtl/pipe_pkg.sv | 17 +
 rtl/pipe_slot.sv | 25 ++
 rtl/pipe_stage_latch.sv | 133 +++++++++++++
 tb/tb_pipe_stage_latch.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared state type and default widths for the pipeline-stage latch.
package pipe_pkg;

  typedef enum logic [1:0] {PS_EMPTY, PS_ONE, PS_TWO} pipe_state_t;

  localparam int PIPE_CTRL_W_DEF = 8;
  localparam int PIPE_DATA_W_DEF = 128;

  function automatic logic [1:0] state_count(input pipe_state_t s);
    case (s)
      PS_ONE:  return 2'd1;
      PS_TWO:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One ctrl+data storage register with load enable; cleared only by reset.
module pipe_slot #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 128
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load,
  input  logic [CTRL_W-1:0] next_ctrl,
  input  logic [DATA_W-1:0] next_data,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ctrl <= '0;
      data <= '0;
    end else if (load) begin
      ctrl <= next_ctrl;
      data <= next_data;
    end
  end

endmodule

// File: rtl/pipe_stage_latch.sv
// Pipeline-stage register with valid/ready handshake, flush and bubble zeroing.
// Defining PIPE_LATCH_SKID_EN adds a second (skid) slot and a registered in_ready.
//
// state    | meaning
// PS_EMPTY | no entry held, outputs show a bubble
// PS_ONE   | head slot H valid
// PS_TWO   | H and skid slot S valid, input stalled
module pipe_stage_latch
  import pipe_pkg::*;
#(
  parameter int CTRL_W = PIPE_CTRL_W_DEF,
  parameter int DATA_W = PIPE_DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);

  pipe_state_t       state, state_nxt;
  logic              take_in, take_out, h_load;
  logic [CTRL_W-1:0] h_ctrl, h_next_ctrl;
  logic [DATA_W-1:0] h_next_data;

  assign out_valid = (state != PS_EMPTY);
  assign take_in   = in_valid & in_ready & ~flush;
  assign take_out  = out_valid & out_ready;

`ifdef PIPE_LATCH_SKID_EN
  logic              s_load;
  logic [CTRL_W-1:0] s_ctrl;
  logic [DATA_W-1:0] s_data;

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
    .CLK       (CLK),
    .RST       (RST),
    .load      (s_load),
    .next_ctrl (in_ctrl),
    .next_data (in_data),
    .ctrl      (s_ctrl),
    .data      (s_data)
  );

  // H only ever refills from S while two entries are held
  assign h_next_ctrl = (state == PS_TWO) ? s_ctrl : in_ctrl;
  assign h_next_data = (state == PS_TWO) ? s_data : in_data;
`else
  assign h_next_ctrl = in_ctrl;
  assign h_next_data = in_data;
  assign in_ready    = ~out_valid | out_ready;
`endif

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_head (
    .CLK       (CLK),
    .RST       (RST),
    .load      (h_load),
    .next_ctrl (h_next_ctrl),
    .next_data (h_next_data),
    .ctrl      (h_ctrl),
    .data      (out_data)
  );

  always_comb begin
    state_nxt = state;
    h_load    = 1'b0;
`ifdef PIPE_LATCH_SKID_EN
    s_load    = 1'b0;
`endif
    case (state)
      PS_EMPTY: begin
        if (take_in) begin
          state_nxt = PS_ONE;
          h_load    = 1'b1;
        end
      end
      PS_ONE: begin
        if (take_in && take_out) begin
          h_load = 1'b1;
`ifdef PIPE_LATCH_SKID_EN
        end else if (take_in) begin
          s_load    = 1'b1;
          state_nxt = PS_TWO;
`endif
        end else if (take_out) begin
          state_nxt = PS_EMPTY;
        end
      end
`ifdef PIPE_LATCH_SKID_EN
      PS_TWO: begin
        if (take_out) begin
          state_nxt = PS_ONE;
          h_load    = 1'b1;
        end
      end
`endif
      default: state_nxt = PS_EMPTY;
    endcase
    // flush empties the stage but leaves stored payload untouched
    if (flush) begin
      state_nxt = PS_EMPTY;
      h_load    = 1'b0;
`ifdef PIPE_LATCH_SKID_EN
      s_load    = 1'b0;
`endif
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= PS_EMPTY;
`ifdef PIPE_LATCH_SKID_EN
      in_ready <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
`ifdef PIPE_LATCH_SKID_EN
      in_ready <= (state_nxt != PS_TWO);
`endif
    end
  end

  assign out_ctrl = out_valid ? h_ctrl : '0;
  assign count    = state_count(state);

endmodule

// File: tb/tb_pipe_stage_latch.sv
// Bench for pipe_stage_latch: vector table, corner sequences, randomized queue-model run.
module tb_pipe_stage_latch;
  import pipe_pkg::*;

  localparam int CW = PIPE_CTRL_W_DEF;
  localparam int DW = PIPE_DATA_W_DEF;
`ifdef PIPE_LATCH_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic          in_ready, out_valid;
  logic [CW-1:0] in_ctrl = '0, out_ctrl;
  logic [DW-1:0] in_data = '0, out_data;
  logic [1:0]    count;

  int passed = 0;
  int total  = 0;

  always #5 CLK = ~CLK;

  pipe_stage_latch #(.CTRL_W(CW), .DATA_W(DW)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .count(count)
  );

  typedef struct {
    logic          iv, orr;
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    logic          ev;
    logic [CW-1:0] ec;
    logic [DW-1:0] ed;
    logic [1:0]    en;
    logic          er;
  } vec_t;
  vec_t vecs[10];

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;
  ent_t q[$];
  logic m_rdy;

  function automatic vec_t mk(input logic iv, orr, input logic [CW-1:0] c, input logic [DW-1:0] d,
                              input logic ev, input logic [CW-1:0] ec, input logic [DW-1:0] ed,
                              input logic [1:0] en, input logic er);
    vec_t v;
    v.iv = iv; v.orr = orr; v.c = c; v.d = d;
    v.ev = ev; v.ec = ec; v.ed = ed; v.en = en; v.er = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [CW-1:0] c,
                            input logic [DW-1:0] d, input logic [1:0] n, input logic r, input bit chk_d);
    chk({tag, "_valid"}, out_valid, v);
    chk({tag, "_ctrl"},  out_ctrl,  c);
    chk({tag, "_count"}, count,     n);
    chk({tag, "_ready"}, in_ready,  r);
    if (chk_d) chk({tag, "_data"}, out_data, d);
  endtask

  task automatic drive(input logic iv, orr, fl, input logic [CW-1:0] c, input logic [DW-1:0] d);
    in_valid = iv; out_ready = orr; flush = fl; in_ctrl = c; in_data = d;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic model_ready();
    if (SKID) return m_rdy;
    return (q.size() == 0) || out_ready;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic          tin, tout;
    logic [CW-1:0] ec;
    ent_t          e;

    // reset then stream of 1..4, then a bubble run after a ctrl=FF entry
    vecs[0] = mk(0, 1, 8'h00, 0, 0, 8'h00, 0, 2'd0, 1);
    vecs[1] = mk(1, 1, 8'h5A, 1, 1, 8'h5A, 1, 2'd1, 1);
    vecs[2] = mk(1, 1, 8'h5A, 2, 1, 8'h5A, 2, 2'd1, 1);
    vecs[3] = mk(1, 1, 8'h5A, 3, 1, 8'h5A, 3, 2'd1, 1);
    vecs[4] = mk(1, 1, 8'h5A, 4, 1, 8'h5A, 4, 2'd1, 1);
    vecs[5] = mk(0, 1, 8'h00, 0, 0, 8'h00, 0, 2'd0, 1);
    vecs[6] = mk(1, 1, 8'hFF, 5, 1, 8'hFF, 5, 2'd1, 1);
    vecs[7] = mk(0, 1, 8'h00, 0, 0, 8'h00, 0, 2'd0, 1);
    vecs[8] = mk(0, 1, 8'h00, 0, 0, 8'h00, 0, 2'd0, 1);
    vecs[9] = mk(0, 1, 8'h00, 0, 0, 8'h00, 0, 2'd0, 1);

    drive(0, 0, 0, 0, 0);
    RST = 1'b1;
    tick();
    expect_out("reset", 0, 8'h00, 0, 2'd0, SKID ? 1'b0 : 1'b1, 1);
    tick();
    RST = 1'b0;

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].iv, vecs[i].orr, 0, vecs[i].c, vecs[i].d);
      tick();
      expect_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ec, vecs[i].ed, vecs[i].en,
                 vecs[i].er, vecs[i].ev || i == 0);
    end

`ifdef PIPE_LATCH_SKID_EN
    // backpressure: 7 accepted, then out_ready drops while 8 and 9 are offered
    drive(1, 1, 0, 8'h01, 7); tick(); expect_out("bp_a", 1, 8'h01, 7, 2'd1, 1, 1);
    drive(1, 0, 0, 8'h01, 8); tick(); expect_out("bp_b", 1, 8'h01, 7, 2'd2, 0, 1);
    drive(1, 0, 0, 8'h01, 9); tick(); expect_out("bp_c", 1, 8'h01, 7, 2'd2, 0, 1);
    drive(1, 1, 0, 8'h01, 9); tick(); expect_out("bp_d", 1, 8'h01, 8, 2'd1, 1, 1);
    drive(1, 1, 0, 8'h01, 9); tick(); expect_out("bp_e", 1, 8'h01, 9, 2'd1, 1, 1);
    drive(0, 1, 0, 8'h00, 0); tick(); expect_out("bp_f", 0, 8'h00, 0, 2'd0, 1, 0);

    // flush with two entries held while 0x12 is offered
    drive(1, 0, 0, 8'h33, 'h10); tick(); expect_out("fl_a", 1, 8'h33, 'h10, 2'd1, 1, 1);
    drive(1, 0, 0, 8'h33, 'h11); tick(); expect_out("fl_b", 1, 8'h33, 'h10, 2'd2, 0, 1);
    drive(1, 0, 1, 8'h33, 'h12); tick(); expect_out("fl_c", 0, 8'h00, 0, 2'd0, 1, 0);
    drive(0, 1, 0, 8'h00, 0);    tick(); expect_out("fl_d", 0, 8'h00, 0, 2'd0, 1, 0);

    // asynchronous reset with two entries held
    drive(1, 0, 0, 8'h44, 'h30); tick();
    drive(1, 0, 0, 8'h44, 'h31); tick(); expect_out("ar_a", 1, 8'h44, 'h30, 2'd2, 0, 1);
    drive(0, 0, 0, 8'h00, 0);
    #2 RST = 1'b1;
    #1 expect_out("ar_b", 0, 8'h00, 0, 2'd0, 0, 1);
    tick();
    RST = 1'b0;
    tick(); chk("ar_ready_rise", in_ready, 1'b1);
`else
    // flush with one entry held while 0x12 is offered
    drive(1, 0, 0, 8'h33, 'h10); tick(); expect_out("fl_a", 1, 8'h33, 'h10, 2'd1, 0, 1);
    drive(1, 1, 1, 8'h33, 'h12); tick(); expect_out("fl_b", 0, 8'h00, 0, 2'd0, 1, 0);
    drive(0, 0, 0, 8'h00, 0);    tick(); expect_out("fl_c", 0, 8'h00, 0, 2'd0, 1, 0);

    // asynchronous reset with one entry held
    drive(1, 0, 0, 8'h44, 'h30); tick(); expect_out("ar_a", 1, 8'h44, 'h30, 2'd1, 0, 1);
    drive(0, 0, 0, 8'h00, 0);
    #2 RST = 1'b1;
    #1 expect_out("ar_b", 0, 8'h00, 0, 2'd0, 1, 1);
    tick();
    RST = 1'b0;

    // combinational in_ready follows out_ready in the same cycle
    drive(1, 1, 0, 8'h55, 'h20); tick(); expect_out("st_a", 1, 8'h55, 'h20, 2'd1, 1, 1);
    drive(1, 0, 0, 8'h66, 'h21);
    #1 chk("st_ready_low", in_ready, 1'b0);
    tick(); expect_out("st_b", 1, 8'h55, 'h20, 2'd1, 0, 1);
    out_ready = 1'b1;
    #1 chk("st_ready_high", in_ready, 1'b1);
    tick(); expect_out("st_c", 1, 8'h66, 'h21, 2'd1, 1, 1);
    drive(0, 1, 0, 8'h00, 0); tick(); expect_out("st_d", 0, 8'h00, 0, 2'd0, 1, 0);
`endif

    // randomized run against a FIFO-of-entries model
    RST = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick();
    RST = 1'b0;
    q.delete();
    m_rdy = 1'b0;
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0,
            CW'($urandom), {$urandom, $urandom, $urandom, $urandom});
      #1;
      chk("rnd_in_ready", in_ready, model_ready());
      tin  = in_valid && model_ready() && !flush;
      tout = (q.size() != 0) && out_ready;
      e.c  = in_ctrl;
      e.d  = in_data;
      @(posedge CLK);
      if (flush) q.delete();
      else begin
        if (tout) void'(q.pop_front());
        if (tin) q.push_back(e);
      end
      m_rdy = (q.size() < 2);
      #1;
      ec = '0;
      if (q.size() != 0) ec = q[0].c;
      chk("rnd_valid", out_valid, q.size() != 0);
      chk("rnd_ctrl", out_ctrl, ec);
      chk("rnd_count", count, q.size());
      if (q.size() != 0) chk("rnd_data", out_data, q[0].d);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
